// File: rtl/tenant_demux_pkg.sv
// Shared types and constants for the tenant demultiplexer: FSM encoding,
// default tenant-ID field placement and a saturating counter helper.
package tenant_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int DEF_TENANT_LSB   = 32;
    localparam int DEF_TENANT_WIDTH = 8;
    localparam int CNT_W            = 32;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/tenant_demux_if.sv
// AXI-Stream bundle. Handshake: a beat transfers on a clock edge where
// tvalid && tready; the source holds payload and tvalid stable until then.
interface tenant_demux_if #(
    parameter int DW = 256,
    parameter int UW = 128
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0]   tuser;
    logic            tvalid;
    logic            tlast;
    logic            tready;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/tenant_demux_axis_reg_slot.sv
// One-entry output register slot. Free when empty or being drained this
// cycle, so a drain and a refill in the same cycle keep full throughput.
module axis_reg_slot #(
    parameter int DW = 256,
    parameter int KW = 32,
    parameter int UW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr,
    input  logic [DW-1:0] i_tdata,
    input  logic [KW-1:0] i_tkeep,
    input  logic [UW-1:0] i_tuser,
    input  logic          i_tlast,
    input  logic          i_tready,
    output logic          o_free,
    output logic          o_tvalid,
    output logic [DW-1:0] o_tdata,
    output logic [KW-1:0] o_tkeep,
    output logic [UW-1:0] o_tuser,
    output logic          o_tlast
);
    logic          r_valid;
    logic [DW-1:0] r_tdata;
    logic [KW-1:0] r_tkeep;
    logic [UW-1:0] r_tuser;
    logic          r_tlast;

    assign o_free   = !r_valid || i_tready;
    assign o_tvalid = r_valid;
    assign o_tdata  = r_tdata;
    assign o_tkeep  = r_tkeep;
    assign o_tuser  = r_tuser;
    assign o_tlast  = r_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_tdata <= '0;
            r_tkeep <= '0;
            r_tuser <= '0;
            r_tlast <= 1'b0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_tdata <= i_tdata;
            r_tkeep <= i_tkeep;
            r_tuser <= i_tuser;
            r_tlast <= i_tlast;
        end else if (i_tready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/tenant_demux.sv
// Routes each incoming packet to one of three tenant outputs using the tenant
// ID carried in tuser of the head beat; packets for unknown tenants are dropped.
module tenant_demux
    import tenant_demux_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 3,
    parameter int TENANT_LSB           = DEF_TENANT_LSB,
    parameter int TENANT_WIDTH         = DEF_TENANT_WIDTH
) (
    input  logic                   axis_aclk,
    input  logic                   axis_resetn,
    tenant_demux_if.slave          s_axis,
    tenant_demux_if.master         m_axis_0,
    tenant_demux_if.master         m_axis_1,
    tenant_demux_if.master         m_axis_2,
    output logic [CNT_W-1:0]       drop_count,
    output logic [CNT_W-1:0]       pkt_count_0,
    output logic [CNT_W-1:0]       pkt_count_1,
    output logic [CNT_W-1:0]       pkt_count_2,
    output state_t                 o_dbg_state
);
    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int SEL_W = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam logic [TENANT_WIDTH-1:0] NQ_TID = TENANT_WIDTH'(NUM_QUEUES);

    state_t                  r_state;
    state_t                  w_next;
    logic [SEL_W-1:0]        r_sel;
    logic [CNT_W-1:0]        r_drop_count;
    logic [CNT_W-1:0]        r_pkt_cnt [NUM_QUEUES];

    logic [TENANT_WIDTH-1:0] w_tid;
    logic                    w_tid_ok;
    logic [SEL_W-1:0]        w_tid_sel;
    logic                    w_tready;
    logic                    w_latch;
    logic                    w_drop_inc;
    logic [NUM_QUEUES-1:0]   w_wr;
    logic [NUM_QUEUES-1:0]   w_free;
    logic [NUM_QUEUES-1:0]   w_m_tvalid;
    logic [NUM_QUEUES-1:0]   w_m_tlast;
    logic [NUM_QUEUES-1:0]   w_m_tready;
    logic [DW-1:0]           w_m_tdata [NUM_QUEUES];
    logic [KW-1:0]           w_m_tkeep [NUM_QUEUES];
    logic [UW-1:0]           w_m_tuser [NUM_QUEUES];

    assign w_tid     = s_axis.tuser[TENANT_LSB +: TENANT_WIDTH];
    assign w_tid_ok  = (w_tid < NQ_TID);
    assign w_tid_sel = w_tid[SEL_W-1:0];

    // Held low through reset so nothing is accepted before the FSM is live.
    assign s_axis.tready = w_tready & axis_resetn;

    always_comb begin
        w_next     = r_state;
        w_tready   = 1'b0;
        w_wr       = '0;
        w_latch    = 1'b0;
        w_drop_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tid_ok) begin
                    w_tready = w_free[w_tid_sel];
                    if (s_axis.tvalid && w_tready) begin
                        w_wr[w_tid_sel] = 1'b1;
                        w_latch         = 1'b1;
                        w_next          = s_axis.tlast ? ST_IDLE : ST_FWD;
                    end
                end else begin
                    w_tready = 1'b1;
                    if (s_axis.tvalid) begin
                        w_drop_inc = 1'b1;
                        w_next     = s_axis.tlast ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                w_tready = w_free[r_sel];
                if (s_axis.tvalid && w_tready) begin
                    w_wr[r_sel] = 1'b1;
                    if (s_axis.tlast) w_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                w_tready = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_drop_count <= '0;
            for (int q = 0; q < NUM_QUEUES; q++) r_pkt_cnt[q] <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) r_sel <= w_tid_sel;
            if (w_drop_inc) r_drop_count <= sat_inc(r_drop_count);
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (w_wr[q] && s_axis.tlast) r_pkt_cnt[q] <= sat_inc(r_pkt_cnt[q]);
            end
        end
    end

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_slot
        axis_reg_slot #(.DW(DW), .KW(KW), .UW(UW)) u_slot (
            .clk      (axis_aclk),
            .rst_n    (axis_resetn),
            .i_wr     (w_wr[q]),
            .i_tdata  (s_axis.tdata),
            .i_tkeep  (s_axis.tkeep),
            .i_tuser  (s_axis.tuser),
            .i_tlast  (s_axis.tlast),
            .i_tready (w_m_tready[q]),
            .o_free   (w_free[q]),
            .o_tvalid (w_m_tvalid[q]),
            .o_tdata  (w_m_tdata[q]),
            .o_tkeep  (w_m_tkeep[q]),
            .o_tuser  (w_m_tuser[q]),
            .o_tlast  (w_m_tlast[q])
        );
    end

    // Fixed three-port mapping expected by the downstream arbiter.
    assign w_m_tready = {m_axis_2.tready, m_axis_1.tready, m_axis_0.tready};

    assign m_axis_0.tvalid = w_m_tvalid[0];
    assign m_axis_0.tdata  = w_m_tdata[0];
    assign m_axis_0.tkeep  = w_m_tkeep[0];
    assign m_axis_0.tuser  = w_m_tuser[0];
    assign m_axis_0.tlast  = w_m_tlast[0];

    assign m_axis_1.tvalid = w_m_tvalid[1];
    assign m_axis_1.tdata  = w_m_tdata[1];
    assign m_axis_1.tkeep  = w_m_tkeep[1];
    assign m_axis_1.tuser  = w_m_tuser[1];
    assign m_axis_1.tlast  = w_m_tlast[1];

    assign m_axis_2.tvalid = w_m_tvalid[2];
    assign m_axis_2.tdata  = w_m_tdata[2];
    assign m_axis_2.tkeep  = w_m_tkeep[2];
    assign m_axis_2.tuser  = w_m_tuser[2];
    assign m_axis_2.tlast  = w_m_tlast[2];

    assign drop_count  = r_drop_count;
    assign pkt_count_0 = r_pkt_cnt[0];
    assign pkt_count_1 = r_pkt_cnt[1];
    assign pkt_count_2 = r_pkt_cnt[2];
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_tenant_demux.sv
// Directed and randomized checks of tenant_demux against a queue-based
// model of where each accepted beat must appear and what the counters read.
module tb_tenant_demux;
    import tenant_demux_pkg::*;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;
    localparam int NQ = 3;
    localparam int EW = 1 + KW + UW + DW;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    tenant_demux_if #(.DW(DW), .UW(UW)) s_if ();
    tenant_demux_if #(.DW(DW), .UW(UW)) m0_if ();
    tenant_demux_if #(.DW(DW), .UW(UW)) m1_if ();
    tenant_demux_if #(.DW(DW), .UW(UW)) m2_if ();

    logic [2:0]  m_rdy = 3'b111;
    logic [31:0] drop_count, pkt_count_0, pkt_count_1, pkt_count_2;
    state_t      dbg_state;

    assign m0_if.tready = m_rdy[0];
    assign m1_if.tready = m_rdy[1];
    assign m2_if.tready = m_rdy[2];

    tenant_demux #(
        .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .NUM_QUEUES(NQ),
        .TENANT_LSB(32), .TENANT_WIDTH(8)
    ) dut (
        .axis_aclk  (clk),
        .axis_resetn(rst_n),
        .s_axis     (s_if),
        .m_axis_0   (m0_if),
        .m_axis_1   (m1_if),
        .m_axis_2   (m2_if),
        .drop_count (drop_count),
        .pkt_count_0(pkt_count_0),
        .pkt_count_1(pkt_count_1),
        .pkt_count_2(pkt_count_2),
        .o_dbg_state(dbg_state)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: beats accepted but not yet delivered, per output
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q2[$];
    logic [31:0]   exp_drop = 0;
    logic [31:0]   exp_pkt [NQ];
    bit            m_in_pkt = 0;
    bit            m_dropping = 0;
    int            m_dest = 0;
    bit            saw_stall = 0;
    bit            rand_rdy = 0;

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic int qsize(input int n);
        case (n)
            0: return exp_q0.size();
            1: return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [EW-1:0] qfront(input int n);
        case (n)
            0: return exp_q0[0];
            1: return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    function automatic void qpop(input int n);
        case (n)
            0: void'(exp_q0.pop_front());
            1: void'(exp_q1.pop_front());
            default: void'(exp_q2.pop_front());
        endcase
    endfunction

    function automatic void qpush(input int n, input logic [EW-1:0] v);
        case (n)
            0: exp_q0.push_back(v);
            1: exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endfunction

    function automatic logic out_valid(input int n);
        case (n)
            0: return m0_if.tvalid;
            1: return m1_if.tvalid;
            default: return m2_if.tvalid;
        endcase
    endfunction

    function automatic logic [EW-1:0] out_beat(input int n);
        case (n)
            0: return {m0_if.tlast, m0_if.tkeep, m0_if.tuser, m0_if.tdata};
            1: return {m1_if.tlast, m1_if.tkeep, m1_if.tuser, m1_if.tdata};
            default: return {m2_if.tlast, m2_if.tkeep, m2_if.tuser, m2_if.tdata};
        endcase
    endfunction

    // monitor: sampled on the falling edge, predicting the next rising edge
    logic          mon_rdy;
    int            mon_tid;
    logic [EW-1:0] mon_beat;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            exp_q2.delete();
            exp_drop = 0;
            for (int n = 0; n < NQ; n++) exp_pkt[n] = 0;
            m_in_pkt = 0;
            chk("rst_s_tready", EW'(s_if.tready), EW'(0));
            chk("rst_m_tvalid", EW'({m2_if.tvalid, m1_if.tvalid, m0_if.tvalid}), EW'(0));
            chk("rst_counters", EW'({drop_count, pkt_count_2, pkt_count_1, pkt_count_0}), EW'(0));
        end else begin
            mon_tid = int'(s_if.tuser[39:32]);
            if (!m_in_pkt)
                mon_rdy = (mon_tid < NQ) ? (qsize(mon_tid) == 0 || m_rdy[mon_tid]) : 1'b1;
            else if (m_dropping)
                mon_rdy = 1'b1;
            else
                mon_rdy = (qsize(m_dest) == 0 || m_rdy[m_dest]);
            chk("s_tready", EW'(s_if.tready), EW'(mon_rdy));
            if (s_if.tvalid && !s_if.tready) saw_stall = 1;

            chk("drop_count", EW'(drop_count), EW'(exp_drop));
            chk("pkt_counts", EW'({pkt_count_2, pkt_count_1, pkt_count_0}),
                EW'({exp_pkt[2], exp_pkt[1], exp_pkt[0]}));

            for (int n = 0; n < NQ; n++) begin
                chk($sformatf("m%0d_tvalid", n), EW'(out_valid(n)), EW'(qsize(n) != 0));
                if (qsize(n) != 0) begin
                    chk($sformatf("m%0d_payload", n), out_beat(n), qfront(n));
                    if (m_rdy[n]) qpop(n);
                end
            end

            if (s_if.tvalid && s_if.tready) begin
                mon_beat = {s_if.tlast, s_if.tkeep, s_if.tuser, s_if.tdata};
                if (!m_in_pkt) begin
                    if (mon_tid < NQ) begin
                        qpush(mon_tid, mon_beat);
                        m_dest = mon_tid;
                        m_dropping = 0;
                        if (s_if.tlast) exp_pkt[mon_tid] = sat(exp_pkt[mon_tid]);
                    end else begin
                        exp_drop = sat(exp_drop);
                        m_dropping = 1;
                    end
                    m_in_pkt = !s_if.tlast;
                end else begin
                    if (!m_dropping) begin
                        qpush(m_dest, mon_beat);
                        if (s_if.tlast) exp_pkt[m_dest] = sat(exp_pkt[m_dest]);
                    end
                    if (s_if.tlast) m_in_pkt = 0;
                end
            end
        end
    end

    // random downstream back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) m_rdy = 3'($urandom);
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [7:0] tid, input bit head, input bit last);
        logic [UW-1:0] u;
        logic [DW-1:0] d;
        bit acc;
        acc = 0;
        for (int i = 0; i < UW / 32; i++) u[i*32 +: 32] = $urandom;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        if (head) u[39:32] = tid;
        s_if.tdata  = d;
        s_if.tkeep  = $urandom;
        s_if.tuser  = u;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if (s_if.tready) acc = 1;
        end
        chk("beat_accept", EW'(acc), EW'(1));
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] tid, input int nbeats);
        for (int b = 0; b < nbeats; b++) drive_beat(tid, b == 0, b == nbeats - 1);
    endtask

    int c0;
    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        m_rdy       = 3'b111;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // single-beat packet to tenant 1
        send_pkt(8'd1, 1);
        idle(3);
        chk("t031_counts", EW'({pkt_count_2, pkt_count_1, pkt_count_0}), EW'({32'd0, 32'd1, 32'd0}));

        // 4-beat packet to tenant 2 under back-pressure
        m_rdy[2] = 1'b0;
        saw_stall = 0;
        fork
            send_pkt(8'd2, 4);
            begin
                repeat (3) @(posedge clk);
                #1 m_rdy[2] = 1'b1;
            end
        join
        idle(3);
        chk("t032_stall_seen", EW'(saw_stall), EW'(1));
        chk("t032_counts", EW'({pkt_count_2, pkt_count_1, pkt_count_0}), EW'({32'd1, 32'd1, 32'd0}));

        // invalid tenant is dropped
        send_pkt(8'd7, 3);
        idle(2);
        chk("t033_drop", EW'(drop_count), EW'(1));

        // back-to-back packets at one beat per cycle
        c0 = cyc;
        send_pkt(8'd0, 2);
        send_pkt(8'd1, 2);
        send_pkt(8'd0, 2);
        send_pkt(8'd2, 2);
        chk("t034_cycles", EW'(cyc - c0), EW'(8));
        idle(3);
        chk("t034_counts", EW'({pkt_count_2, pkt_count_1, pkt_count_0}), EW'({32'd2, 32'd2, 32'd2}));

        // reset in the middle of a packet
        drive_beat(8'd0, 1, 0);
        drive_beat(8'd0, 0, 0);
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        s_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t035_slot_empty", EW'(m0_if.tvalid), EW'(0));
        send_pkt(8'd0, 1);
        idle(3);
        chk("t035_counts", EW'({pkt_count_2, pkt_count_1, pkt_count_0}), EW'({32'd0, 32'd0, 32'd1}));

        // drop counter saturation
        force dut.r_drop_count = 32'hFFFF_FFFF;
        exp_drop = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 release dut.r_drop_count;
        idle(1);
        chk("t036_preload", EW'(drop_count), EW'(32'hFFFF_FFFF));
        send_pkt(8'd5, 1);
        idle(2);
        chk("t036_saturate", EW'(drop_count), EW'(32'hFFFF_FFFF));

        // randomized traffic with random back-pressure
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        rand_rdy = 1;
        for (int p = 0; p < 40; p++) begin
            send_pkt(8'($urandom_range(0, 4)), $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rand_rdy = 0;
        m_rdy = 3'b111;
        idle(5);
        chk("drain_empty", EW'(qsize(0) + qsize(1) + qsize(2)), EW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tenant_demux.md
TENANT_DEMUX -- requirements
Module: tenant_demux

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, input/output tdata width in bits.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, tuser width.
REQ-003 SHALL have parameter NUM_QUEUES, default 3, number of tenant output streams.
REQ-004 SHALL have parameter TENANT_LSB, default 32, tenant-ID bit offset inside tuser.
REQ-005 SHALL have parameter TENANT_WIDTH, default 8, tenant-ID width.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: axis_aclk input 1 clock; axis_resetn input 1 async active-low reset.
REQ-007 SHALL have slave ports s_axis_tdata/tkeep/tuser/tvalid/tlast input (DATA, DATA/8, TUSER, 1, 1), and s_axis_tready output 1.
REQ-008 SHALL have master ports m_axis_<n>_tdata/tkeep/tuser/tvalid/tlast output, and m_axis_<n>_tready input, for n = 0..2.
REQ-009 SHALL have output drop_count, 32 bits: packets discarded for an invalid tenant.
REQ-010 SHALL have output pkt_count_<n>, 32 bits each: packets forwarded to output n.

Function
REQ-011 SHALL decode tid = s_axis_tuser[TENANT_LSB +: TENANT_WIDTH] from the first beat of each packet only; tid < NUM_QUEUES is valid.
REQ-012 SHALL implement FSM states IDLE (awaiting first beat), FWD (forwarding to latched sel), DROP (discarding).
REQ-013 In IDLE, valid tid: s_axis_tready = slot[tid] free. On accept: latch sel = tid; go FWD if !tlast, stay IDLE if tlast.
REQ-014 In IDLE, invalid tid: s_axis_tready = 1. On accept: drop_count+1; go DROP if !tlast, else stay IDLE.
REQ-015 In FWD: s_axis_tready = slot[sel] free. An accepted beat with tlast returns to IDLE.
REQ-016 In DROP: s_axis_tready = 1. Beats are discarded; a tlast beat returns to IDLE.
REQ-017 Each output SHALL have a one-entry register slot holding tdata/tkeep/tuser/tlast. Slot is "free" when empty or m_axis_<n>_tready=1 in the same cycle.
REQ-018 Accepted beat SHALL appear on m_axis_<sel> the cycle after acceptance (latency 1). tvalid SHALL hold until tready; payload SHALL be stable while tvalid && !tready.
REQ-019 Simultaneous slot drain and refill SHALL sustain 1 beat/cycle with no bubble.
REQ-020 Only output sel SHALL ever be written; other slots drain independently.
REQ-021 Packets SHALL never interleave on an output; beat order SHALL be preserved.
REQ-022 pkt_count_<n> SHALL increment when a tlast beat is accepted into slot n.
REQ-023 All counters SHALL saturate at 0xFFFFFFFF (no wrap).
REQ-024 s_axis_tready SHALL depend only on state, tid, and slot occupancy/tready: no combinational path from m_axis tvalid.

Reset
REQ-025 On axis_resetn=0 (asynchronous), SHALL set: state=IDLE, sel=0, all slots empty, all m_axis_<n>_tvalid=0, counters=0.
REQ-026 Reset mid-packet SHALL discard the partial packet. The first beat after reset release SHALL be treated as a packet head.
REQ-027 While reset is asserted, s_axis_tready SHALL be 0.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=0, FWD=1, DROP=2) and the default TENANT_LSB/TENANT_WIDTH constants.
REQ-029 The slot SHALL be one sub-module, axis_reg_slot, instantiated NUM_QUEUES times via generate.
REQ-030 The output port mapping SHALL be explicit for 3 queues, matching the downstream arbiter's fixed 3-port interface.

Verification
REQ-031 Single-beat packet, tid=1, all tready=1 -> beat on m_axis_1 next cycle; pkt_count_1=1; others 0.
REQ-032 4-beat packet, tid=2; m_axis_2_tready low for cycles 2-4 -> s_axis_tready drops once the slot fills; all 4 beats arrive in order; no beat on outputs 0/1.
REQ-033 3-beat packet, tid=7 -> s_axis_tready=1 for all beats; no m_axis tvalid; drop_count=1.
REQ-034 Back-to-back packets tid 0,1,0,2, 2 beats each, all tready=1 -> 1 beat/cycle throughput; pkt_count = 2,1,1.
REQ-035 Reset asserted on beat 2 of a 4-beat tid=0 packet, then a new 1-beat tid=0 packet -> slot empty after reset; only the new packet is output; pkt_count_0=1.
REQ-036 drop_count preloaded via force to 0xFFFFFFFF, then one invalid packet -> drop_count stays 0xFFFFFFFF.
